// File: rtl/mem_pkg.sv
// Shared constants and types for the memory responder.
package mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  // The write counter stops here instead of wrapping back to zero.
  localparam logic [31:0] WRITE_COUNT_MAX = 32'hFFFF_FFFF;

  // CLEAR zero-fills the RAM after reset. RUN services accesses.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_responder_if.sv
// Bus between the processor (master) and the memory responder (slave).
import mem_pkg::*;

interface memory_responder_if #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  // Protocol: there is no valid/ready handshake on individual accesses.
  // The master presents address every cycle, and every rising edge samples it
  // as a read. writeEnable=1 at an edge is a write of dataToMemory to address.
  // Writes are accepted only while memReady=1. A write made while memReady=0
  // is discarded and reported by a one-cycle writeDropped pulse.
  // dataFromMemory returns the read data a fixed READ_LATENCY edges later.
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dataToMemory;
  logic                  writeEnable;
  logic [DATA_WIDTH-1:0] dataFromMemory;
  logic                  memReady;
  logic [31:0]           writeCount;
  logic                  writeDropped;

  modport master (
    output address, dataToMemory, writeEnable,
    input  dataFromMemory, memReady, writeCount, writeDropped
  );

  modport slave (
    input  address, dataToMemory, writeEnable,
    output dataFromMemory, memReady, writeCount, writeDropped
  );

endinterface

// File: rtl/read_delay_line.sv
// Shift register with a fixed number of stages that delays read data.
// Every stage clears to zero on reset.
module read_delay_line #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift data through the stages by one position on each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign delayed = stage_q[STAGES-1];

endmodule

// File: rtl/memory_responder.sv
// Single-port RAM responder with a zero-fill sweep after reset,
// a configurable read latency and a saturating write counter.
import mem_pkg::*;

module memory_responder #(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  memory_responder_if.slave   bus,
  output mem_state_t          fsm_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  // Stop elaboration when the read latency is outside 1..4.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("memory_responder: READ_LATENCY must be in 1..4");
  end

  mem_state_t            state;
  mem_state_t            next_state;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_out;
  logic [31:0]           write_count;
  logic                  write_dropped;
  logic                  running;

  assign running = (state == RUN);

  // State register. Reset always restarts the sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  // Leave CLEAR when the last address is zeroed. RUN holds until reset.
  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clear_addr == LAST_ADDR) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  // Sweep pointer. It steps once per cycle while clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               clear_addr <= '0;
    else if (state == CLEAR) clear_addr <= clear_addr + 1'b1;
  end

  // RAM array, which has no reset. The sweep owns the write port during CLEAR.
  always_ff @(posedge clk) begin
    if (state == CLEAR)       mem[clear_addr]  <= '0;
    else if (bus.writeEnable) mem[bus.address] <= bus.dataToMemory;
  end

  // Read stage 1: the RAM output register. A same-address write is returned
  // directly, so the read sees the new data (write-first).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                rd_q <= '0;
    else if (!running)        rd_q <= '0;
    else if (bus.writeEnable) rd_q <= bus.dataToMemory;
    else                      rd_q <= mem[bus.address];
  end

  // Stages 2..READ_LATENCY. Data already here is not changed by later writes.
  if (READ_LATENCY > 1) begin : g_delay
    read_delay_line #(
      .WIDTH  (DATA_WIDTH),
      .STAGES (READ_LATENCY - 1)
    ) u_read_delay_line (
      .clk     (clk),
      .reset   (reset),
      .data    (rd_q),
      .delayed (rd_out)
    );
  end else begin : g_no_delay
    assign rd_out = rd_q;
  end

  // Count accepted writes. The counter holds at its maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_count <= '0;
    end else if (running && bus.writeEnable && write_count != WRITE_COUNT_MAX) begin
      write_count <= write_count + 32'd1;
    end
  end

  // Pulse for one cycle after a write is discarded during the sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) write_dropped <= 1'b0;
    else       write_dropped <= !running && bus.writeEnable;
  end

  assign bus.dataFromMemory = rd_out;
  assign bus.memReady       = running;
  assign bus.writeCount     = write_count;
  assign bus.writeDropped   = write_dropped;
  assign fsm_state          = state;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder. Two instances receive the same
// stimulus: one has READ_LATENCY=1 and the other READ_LATENCY=3.
import mem_pkg::*;

module tb_memory_responder;

  localparam int DW = 16;
  localparam int AW = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  mem_state_t    state1;
  mem_state_t    state3;

  int n_checks = 0;
  int n_fail   = 0;
  int model_count;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];

  memory_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  memory_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

  assign bus1.address      = addr;
  assign bus1.dataToMemory = wdata;
  assign bus1.writeEnable  = we;
  assign bus3.address      = addr;
  assign bus3.dataToMemory = wdata;
  assign bus3.writeEnable  = we;

  memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1.slave),
    .fsm_state (state1)
  );

  memory_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus3.slave),
    .fsm_state (state3)
  );

  // Clock and reset generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Release reset and follow the 16-cycle sweep. When inject is set, a write
  // is made in cycle 4 and must be dropped, with a pulse in cycle 5.
  task automatic run_sweep(input bit inject);
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      check("ready_low_sweep1", 32'(bus1.memReady), 32'd0);
      check("ready_low_sweep3", 32'(bus3.memReady), 32'd0);
      if (inject && c == 4) begin
        we = 1'b1; addr = 4'd2; wdata = 16'h7777;
      end else begin
        we = 1'b0;
      end
      tick();
      check("dropped1", 32'(bus1.writeDropped), 32'((inject && c + 1 == 5) ? 1 : 0));
      check("dropped3", 32'(bus3.writeDropped), 32'((inject && c + 1 == 5) ? 1 : 0));
    end
    we = 1'b0;
    check("ready_high1", 32'(bus1.memReady), 32'd1);
    check("ready_high3", 32'(bus3.memReady), 32'd1);
    check("state_run1", 32'(state1), 32'(RUN));
    check("count_after_sweep1", bus1.writeCount, 32'd0);
    check("count_after_sweep3", bus3.writeCount, 32'd0);
  endtask

  function automatic vec_t mk(input logic w, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] e);
    vec_t v;
    v.we = w; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) tick();

    // Reset state
    check("rst_ready1", 32'(bus1.memReady), 32'd0);
    check("rst_data1", 32'(bus1.dataFromMemory), 32'd0);
    check("rst_data3", 32'(bus3.dataFromMemory), 32'd0);
    check("rst_count1", bus1.writeCount, 32'd0);
    check("rst_dropped1", 32'(bus1.writeDropped), 32'd0);
    check("rst_state1", 32'(state1), 32'(CLEAR));

    run_sweep(1'b1);

    // Read every address and expect zero. Address 2 is where the write was dropped.
    for (int a = 0; a < 16; a++) vecs.push_back(mk(1'b0, 4'(a), 16'h0000, 16'h0000));
    // Writes and reads with hand-computed expected data
    vecs.push_back(mk(1'b1, 4'd3,  16'hBEEF, 16'hBEEF));
    vecs.push_back(mk(1'b0, 4'd3,  16'h0000, 16'hBEEF));
    vecs.push_back(mk(1'b1, 4'd5,  16'h1234, 16'h1234));
    vecs.push_back(mk(1'b0, 4'd5,  16'h0000, 16'h1234));
    vecs.push_back(mk(1'b1, 4'd7,  16'h00A5, 16'h00A5));
    vecs.push_back(mk(1'b0, 4'd7,  16'h0000, 16'h00A5));
    vecs.push_back(mk(1'b1, 4'd7,  16'h5A5A, 16'h5A5A));
    vecs.push_back(mk(1'b0, 4'd7,  16'h0000, 16'h5A5A));
    vecs.push_back(mk(1'b0, 4'd3,  16'h0000, 16'hBEEF));
    vecs.push_back(mk(1'b1, 4'd15, 16'hFFFF, 16'hFFFF));
    vecs.push_back(mk(1'b0, 4'd15, 16'h0000, 16'hFFFF));
    vecs.push_back(mk(1'b0, 4'd0,  16'h0000, 16'h0000));
    vecs.push_back(mk(1'b0, 4'd5,  16'h0000, 16'h1234));
    vecs.push_back(mk(1'b0, 4'd7,  16'h0000, 16'h5A5A));

    model_count = 0;
    foreach (vecs[i]) begin
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].data;
      if (vecs[i].we) model_count++;
      exp_q.push_back(vecs[i].exp);
      tick();
      check("rd_lat1", 32'(bus1.dataFromMemory), 32'(vecs[i].exp));
      check("wcount1", bus1.writeCount, 32'(model_count));
      if (exp_q.size() == 3) check("rd_lat3", 32'(bus3.dataFromMemory), 32'(exp_q.pop_front()));
    end
    we = 1'b0;

    // Write to address 9 during RUN, then assert reset mid-operation
    we = 1'b1; addr = 4'd9; wdata = 16'hFFFF;
    tick();
    check("wr9_lat1", 32'(bus1.dataFromMemory), 32'hFFFF);
    we = 1'b0;
    tick(); tick();
    check("wr9_lat3", 32'(bus3.dataFromMemory), 32'hFFFF);
    reset = 1'b1;
    #1;
    check("midrst_ready1", 32'(bus1.memReady), 32'd0);
    check("midrst_ready3", 32'(bus3.memReady), 32'd0);
    check("midrst_data1", 32'(bus1.dataFromMemory), 32'd0);
    check("midrst_data3", 32'(bus3.dataFromMemory), 32'd0);
    check("midrst_count1", bus1.writeCount, 32'd0);
    tick(); tick();
    run_sweep(1'b0);
    addr = 4'd9;
    tick();
    check("after_rst9_lat1", 32'(bus1.dataFromMemory), 32'd0);
    tick(); tick();
    check("after_rst9_lat3", 32'(bus3.dataFromMemory), 32'd0);

    // Saturation of the write counter
    force dut1.write_count = 32'hFFFF_FFFE;
    force dut3.write_count = 32'hFFFF_FFFE;
    #1;
    release dut1.write_count;
    release dut3.write_count;
    check("sat_preload1", bus1.writeCount, 32'hFFFF_FFFE);
    we = 1'b1; addr = 4'd1; wdata = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sat_count1", bus1.writeCount, 32'hFFFF_FFFF);
      check("sat_count3", bus3.writeCount, 32'hFFFF_FFFF);
    end
    we = 1'b0;
    tick();
    check("sat_hold1", bus1.writeCount, 32'hFFFF_FFFF);
    check("run_no_drop1", 32'(bus1.writeDropped), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
